// File: rtl/shift_register_sequencer.sv
// Command-driven controller for a 74194-style 4-bit universal shift register.
// Define SHIFT_SEQ_ROTATE_EN to make op 11 a rotate-right (MSB_in fed live from A_par[0]).
module shift_register_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             CLK,
  input  logic             Clear_b,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_serial,
  input  logic [WIDTH-1:0] A_par,
  output logic [WIDTH-1:0] I_par,
  output logic             s1,
  output logic             s0,
  output logic             MSB_in,
  output logic             LSB_in,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [1:0]         op_q;
  logic [CNT_W-1:0]   remaining;
  logic [WIDTH-1:0]   data_q;
  logic               serial_q;
  logic               accept_c;

  // Only A_par[0] is consumed (and only by rotate); the rest is intentionally ignored.
  logic               a_par_unused;
  assign a_par_unused = ^A_par;

  assign accept_c = cmd_valid && (state == ST_IDLE);

  // State register
  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command latch and shift countdown
  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      op_q      <= '0;
      remaining <= '0;
      data_q    <= '0;
      serial_q  <= 1'b0;
    end else if (accept_c) begin
      op_q      <= cmd_op;
      remaining <= cmd_count;
      data_q    <= cmd_data;
      serial_q  <= cmd_serial;
    end else if (state == ST_SHIFT) begin
      remaining <= remaining - CNT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          case (cmd_op)
            OP_LOAD: state_next = ST_LOAD;
            OP_SHR,
            OP_SHL:  state_next = (cmd_count != '0) ? ST_SHIFT : ST_DONE;
            OP_ROR: begin
`ifdef SHIFT_SEQ_ROTATE_EN
              state_next = (cmd_count != '0) ? ST_SHIFT : ST_DONE;
`else
              state_next = ST_DONE;
`endif
            end
            default: state_next = ST_DONE;
          endcase
        end
      end
      ST_LOAD:  state_next = ST_DONE;
      ST_SHIFT: begin
        if (remaining == CNT_W'(1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode from registered state and latched command fields
  always_comb begin
    s1        = 1'b0;
    s0        = 1'b0;
    I_par     = '0;
    MSB_in    = 1'b0;
    LSB_in    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    cmd_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
      end
      ST_LOAD: begin
        s1    = 1'b1;
        s0    = 1'b1;
        I_par = data_q;
      end
      ST_SHIFT: begin
        case (op_q)
          OP_SHR: begin
            s0     = 1'b1;
            MSB_in = serial_q;
          end
          OP_SHL: begin
            s1     = 1'b1;
            LSB_in = serial_q;
          end
`ifdef SHIFT_SEQ_ROTATE_EN
          OP_ROR: begin
            s0     = 1'b1;
            MSB_in = A_par[0];
          end
`endif
          default: begin
            s1 = 1'b0;
            s0 = 1'b0;
          end
        endcase
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Bench for shift_register_sequencer: a behavioural 74194 closes the A_par loop;
// directed table, hand-written reset/abort sequences and random commands vs an arithmetic model.
module tb_shift_register_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             CLK;
  logic             Clear_b;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_serial;
  logic [WIDTH-1:0] A_par;
  logic [WIDTH-1:0] I_par;
  logic             s1;
  logic             s0;
  logic             MSB_in;
  logic             LSB_in;
  logic             busy;
  logic             done;
  logic             reg_clr_b;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] op;
    logic [2:0] cnt;
    logic [3:0] data;
    logic       ser;
    logic [3:0] exp_a;
    int         lat;
  } vec_t;

  vec_t tbl[9];

  shift_register_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .Clear_b    (Clear_b),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_count  (cmd_count),
    .cmd_data   (cmd_data),
    .cmd_serial (cmd_serial),
    .A_par      (A_par),
    .I_par      (I_par),
    .s1         (s1),
    .s0         (s0),
    .MSB_in     (MSB_in),
    .LSB_in     (LSB_in),
    .busy       (busy),
    .done       (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 74194-style register on its own reset so an aborted command leaves its contents visible
  always_ff @(posedge CLK or negedge reg_clr_b) begin
    if (!reg_clr_b) begin
      A_par <= '0;
    end else begin
      case ({s1, s0})
        2'b01:   A_par <= {MSB_in, A_par[3:1]};
        2'b10:   A_par <= {A_par[2:0], LSB_in};
        2'b11:   A_par <= I_par;
        default: A_par <= A_par;
      endcase
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] pack(input logic [1:0] m, input logic [3:0] ip, input logic mi,
                                       input logic li, input logic b, input logic d, input logic r);
    return {m, ip, mi, li, b, d, r};
  endfunction

  function automatic logic [10:0] obs();
    return {s1, s0, I_par, MSB_in, LSB_in, busy, done, cmd_ready};
  endfunction

  // Final register contents after a command, from the shift rules
  function automatic logic [3:0] ref_a(input logic [3:0] a, input logic [1:0] op, input int n,
                                       input logic [3:0] d, input logic f);
    logic [3:0] full;
    logic [3:0] res;
    int r;
    full = 4'hF;
    r = n % 4;
    case (op)
      2'd0: res = d;
      2'd1: res = (a >> n) | (f ? ~(full >> n) : 4'h0);
      2'd2: res = (a << n) | (f ? ~(full << n) : 4'h0);
      default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
        res = (a >> r) | (a << (4 - r));
`else
        res = a;
`endif
      end
    endcase
    return res;
  endfunction

  // Cycles from accept edge to the done cycle
  function automatic int ref_lat(input logic [1:0] op, input int n);
    int l;
    case (op)
      2'd0: l = 2;
      2'd1, 2'd2: l = (n == 0) ? 1 : n + 1;
      default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
        l = (n == 0) ? 1 : n + 1;
`else
        l = 1;
`endif
      end
    endcase
    return l;
  endfunction

  task automatic scramble();
    cmd_op     = 2'($urandom_range(0, 3));
    cmd_count  = 3'($urandom_range(0, 7));
    cmd_data   = 4'($urandom_range(0, 15));
    cmd_serial = 1'($urandom_range(0, 1));
  endtask

  // Issue one command, check every cycle through done, then the idle state and register contents.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                         input logic ser, input logic [3:0] exp_a, input int lat, input string name);
    logic [10:0] e;
    @(negedge CLK);
    check({name, " ready"}, 16'(cmd_ready), 16'(1'b1));
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_count  = cnt;
    cmd_data   = data;
    cmd_serial = ser;
    for (int k = 1; k <= lat; k++) begin
      @(negedge CLK);
      if (k < lat) begin
        case (op)
          2'd0:    e = pack(2'b11, data, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
          2'd1:    e = pack(2'b01, 4'h0, ser, 1'b0, 1'b1, 1'b0, 1'b0);
          2'd2:    e = pack(2'b10, 4'h0, 1'b0, ser, 1'b1, 1'b0, 1'b0);
          default: e = pack(2'b01, 4'h0, A_par[0], 1'b0, 1'b1, 1'b0, 1'b0);
        endcase
      end else begin
        e = pack(2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      end
      check($sformatf("%s cyc%0d", name, k), 16'(obs()), 16'(e));
      // Requester keeps valid high while busy; changing fields must not disturb the latched command
      if (k == lat) cmd_valid = 1'b0;
      scramble();
    end
    @(negedge CLK);
    check({name, " idle"}, 16'(obs()), 16'(pack(2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));
    check({name, " A_par"}, 16'(A_par), 16'(exp_a));
  endtask

  initial begin
    logic [10:0] idle_v;
    logic [1:0]  r_op;
    logic [2:0]  r_cnt;
    logic [3:0]  r_data;
    logic        r_ser;
    logic [3:0]  r_exp;
    idle_v = pack(2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    tbl[0] = '{2'd0, 3'd0, 4'b1010, 1'b0, 4'b1010, 2};
    tbl[1] = '{2'd1, 3'd2, 4'b0000, 1'b1, 4'b1110, 3};
    tbl[2] = '{2'd0, 3'd5, 4'b1011, 1'b1, 4'b1011, 2};
    tbl[3] = '{2'd2, 3'd3, 4'b0110, 1'b0, 4'b1000, 4};
    tbl[4] = '{2'd1, 3'd0, 4'b1111, 1'b1, 4'b1000, 1};
    tbl[5] = '{2'd0, 3'd0, 4'b1010, 1'b0, 4'b1010, 2};
`ifdef SHIFT_SEQ_ROTATE_EN
    tbl[6] = '{2'd3, 3'd1, 4'b0000, 1'b1, 4'b0101, 2};
    tbl[7] = '{2'd3, 3'd4, 4'b0000, 1'b0, 4'b0101, 5};
`else
    tbl[6] = '{2'd3, 3'd1, 4'b0000, 1'b1, 4'b1010, 1};
    tbl[7] = '{2'd3, 3'd4, 4'b0000, 1'b0, 4'b1010, 1};
`endif
    tbl[8] = '{2'd2, 3'd7, 4'b0000, 1'b1, 4'b1111, 8};

    // Reset held with a command pending: nothing may be accepted
    Clear_b    = 1'b0;
    reg_clr_b  = 1'b0;
    cmd_valid  = 1'b1;
    cmd_op     = 2'd0;
    cmd_count  = 3'd0;
    cmd_data   = 4'hF;
    cmd_serial = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check($sformatf("reset cyc%0d", i), 16'(obs()), 16'(idle_v));
    end
    reg_clr_b = 1'b1;
    @(negedge CLK);
    check("reset hold", 16'(obs()), 16'(idle_v));
    check("reset A_par", 16'(A_par), 16'h0);
    cmd_valid = 1'b0;
    Clear_b   = 1'b1;
    @(negedge CLK);
    check("reset release", 16'(obs()), 16'(idle_v));

    for (int i = 0; i < 9; i++) begin
      run_cmd(tbl[i].op, tbl[i].cnt, tbl[i].data, tbl[i].ser, tbl[i].exp_a, tbl[i].lat,
              $sformatf("tbl%0d", i));
    end

    // Abort a long left shift after two shift edges
    run_cmd(2'd0, 3'd0, 4'b1111, 1'b0, 4'b1111, 2, "abort preload");
    @(negedge CLK);
    cmd_valid  = 1'b1;
    cmd_op     = 2'd2;
    cmd_count  = 3'd7;
    cmd_serial = 1'b0;
    @(negedge CLK);
    check("abort shift1", 16'(obs()), 16'(pack(2'b10, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
    cmd_valid = 1'b0;
    @(negedge CLK);
    check("abort shift2", 16'(obs()), 16'(pack(2'b10, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
    @(negedge CLK);
    Clear_b = 1'b0;
    #1;
    check("abort async", 16'(obs()), 16'(idle_v));
    check("abort A_par", 16'(A_par), 16'b1100);
    @(negedge CLK);
    check("abort no done", 16'(obs()), 16'(idle_v));
    check("abort A_par hold", 16'(A_par), 16'b1100);
    Clear_b = 1'b1;
    @(negedge CLK);
    check("abort recover", 16'(obs()), 16'(idle_v));

    // Random commands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_cnt  = 3'($urandom_range(0, 7));
      r_data = 4'($urandom_range(0, 15));
      r_ser  = 1'($urandom_range(0, 1));
      r_exp  = ref_a(A_par, r_op, int'(r_cnt), r_data, r_ser);
      run_cmd(r_op, r_cnt, r_data, r_ser, r_exp, ref_lat(r_op, int'(r_cnt)),
              $sformatf("rnd%0d op%0d n%0d", i, r_op, r_cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_register_sequencer.md
Name: shift_register_sequencer

Overview:
Command-driven controller for the 4-bit universal shift register (74194-style: s1/s0 mode select, MSB_in/LSB_in serial inputs, I_par parallel load).
- Accepts one command at a time over a valid/ready handshake: parallel load, shift right N or shift left N.
- Drives the register's mode, serial and parallel inputs for the exact number of cycles, then pulses done.
- Sits between a requesting datapath (serialiser, test sequencer) and the shift register; the register's A_par is fed back for optional rotate.

Parameters:
WIDTH, 4, width of register data (I_par/A_par/cmd_data)
CNT_W, 3, width of the shift-count field; max shift count 2**CNT_W-1

Ports:
CLK  input  1  rising-edge clock, shared with the shift register
Clear_b  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  00 load, 01 shift right, 10 shift left, 11 rotate right (see Optional Feature)
cmd_count  input  CNT_W  number of shift cycles (ignored for load)
cmd_data  input  WIDTH  parallel load value
cmd_serial  input  1  fill bit entering the register on shifts
A_par  input  WIDTH  current register contents (feedback)
I_par  output  WIDTH  parallel data to register
s1  output  1  mode select high bit
s0  output  1  mode select low bit
MSB_in  output  1  serial input for shift right
LSB_in  output  1  serial input for shift left
busy  output  1  command in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Mode encoding (register side): s1s0 00 hold, 01 shift right (MSB_in enters bit WIDTH-1), 10 shift left (LSB_in enters bit 0), 11 parallel load.
- Reset (Clear_b low, async): state IDLE, s1s0=00, I_par=0, MSB_in=0, LSB_in=0, busy=0, done=0, cmd_ready=1, internal count=0, latched command regs=0.
- All outputs are decoded from registered state and latched command fields only; no combinational path from cmd_* to any output.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: cmd_ready=1, busy=0, s1s0=00. Handshake occurs on an edge with cmd_valid=1 and cmd_ready=1. At that edge op, count, data and serial are latched.
  - op 00 -> LOAD.
  - op 01/10 with count!=0 -> SHIFT, remaining=count.
  - op 01/10 with count==0 -> DONE.
- LOAD: exactly one cycle. s1s0=11, I_par=latched data. The register captures at the next edge; next state is DONE.
- SHIFT: s1s0=01 (right) or 10 (left). MSB_in (right) or LSB_in (left) = latched serial bit; the other serial input is 0. Each edge decrements remaining; when remaining==1 at the edge, next state is DONE. Exactly `count` shift edges occur.
- DONE: one cycle. s1s0=00, done=1, busy=1, cmd_ready=0. Next state is IDLE.
- busy=1 in LOAD, SHIFT and DONE; cmd_ready=0 in those states. cmd_valid is ignored while busy; the requester holds the command.
- Latency from accept edge to done high: load 2 cycles; shift count N: N+1 cycles; count 0: 1 cycle. Back-to-back throughput: one idle cycle between commands.
- I_par=0 outside LOAD.
- Clear_b asserted mid-command aborts immediately to reset values. No done pulse is produced and the register retains whatever shifts already occurred, unless it shares Clear_b.
- cmd_count values wrap nowhere: the internal counter is CNT_W bits and only counts down to 1.

Optional Feature:
Macro SHIFT_SEQ_ROTATE_EN.
- Defined: op 11 = rotate right by count. Behaves as SHIFT right, but MSB_in = A_par[0] each cycle (live feedback), and cmd_serial is ignored.
- Not defined: op 11 is accepted and goes directly to DONE (count ignored). s1s0 stays 00, the register is unchanged, and done pulses one cycle after accept.

Test Plan:
- Reset: hold Clear_b=0 for 2 cycles with cmd_valid=1 -> s1s0=00, I_par=0000, busy=0, done=0, cmd_ready=1; no command accepted until Clear_b=1.
- Load: op 00, data 1010 -> s1s0=11 and I_par=1010 for exactly one cycle; A_par=1010 afterwards; done high 2 cycles after accept; cmd_ready back the cycle after done.
- Shift right: from A_par=1010, op 01, count 2, serial 1 -> s1s0=01 for exactly 2 cycles, MSB_in=1; A_par=1110; done 3 cycles after accept.
- Shift left plus zero count: from 1011, op 10, count 3, serial 0 -> A_par=1000. Then op 01, count 0 -> s1s0 never leaves 00, done 1 cycle after accept, A_par stays 1000.
- Abort: op 10, count 7 from 1111, serial 0; drop Clear_b after 2 shift edges -> outputs reset asynchronously, no done pulse; A_par=1100 if the register is not on the same reset.
- Rotate: with SHIFT_SEQ_ROTATE_EN, from 1010, op 11, count 1 -> A_par=0101; count 4 -> A_par unchanged after 4 shift cycles. Without the macro, op 11 -> A_par unchanged, done 1 cycle after accept.
